// File: rtl/deflect_port_alloc.sv
// Sequential output-port allocator: grants free ports to up to NSLOT ranked flits, one slot per cycle.
// Define DEFLECT_STATS_EN to compile in the saturating deflection counter on defl_cnt.
module deflect_port_alloc #(
  parameter int NSLOT = 4,
  parameter int NPORT = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NSLOT-1:0]       slot_valid,
  input  logic [NSLOT*NPORT-1:0] prod_mask,
  input  logic [NPORT-1:0]       port_avail,
  output logic                   busy,
  output logic                   done,
  output logic [NSLOT*NPORT-1:0] grant,
  output logic [NSLOT-1:0]       deflected,
  output logic                   err,
  output logic [CNT_W-1:0]       defl_cnt
);

  typedef enum logic [1:0] {IDLE, ALLOC, DONE} state_t;

  state_t                 state;
  logic [NSLOT-1:0]       pend;
  logic [NSLOT*NPORT-1:0] mask;
  logic [NPORT-1:0]       free;

  logic [NSLOT-1:0] sel;
  logic [NSLOT-1:0] pend_next;
  logic [NPORT-1:0] cur_mask;
  logic [NPORT-1:0] cand;
  logic [NPORT-1:0] pool;
  logic [NPORT-1:0] pick;
  logic             deflect_now;
  logic             no_port;

  // Productive candidates are preferred; with none left the flit falls back to any free port.
  always_comb begin
    sel = pend & (~pend + NSLOT'(1));
    pend_next = pend & ~sel;
    cur_mask = '0;
    for (int s = 0; s < NSLOT; s++) begin
      if (sel[s]) cur_mask = mask[s*NPORT +: NPORT];
    end
    cand = cur_mask & free;
    no_port = (free == '0);
    deflect_now = (cand == '0) && !no_port;
    pool = (cand != '0) ? cand : free;
    pick = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (pool[p]) begin
        pick = '0;
        pick[p] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pend      <= '0;
      mask      <= '0;
      free      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      grant     <= '0;
      deflected <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pend      <= slot_valid;
            mask      <= prod_mask;
            free      <= port_avail;
            grant     <= '0;
            deflected <= '0;
            err       <= 1'b0;
            busy      <= 1'b1;
            if (slot_valid != '0) begin
              state <= ALLOC;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        ALLOC: begin
          for (int s = 0; s < NSLOT; s++) begin
            if (sel[s]) grant[s*NPORT +: NPORT] <= pick;
          end
          if (deflect_now) deflected <= deflected | sel;
          if (no_port) err <= 1'b1;
          free <= free & ~pick;
          pend <= pend_next;
          if (pend_next == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DEFLECT_STATS_EN
  localparam int POP_W = $clog2(NSLOT + 1);
  localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;

  logic [SUM_W-1:0] defl_pop;
  logic [SUM_W-1:0] defl_sum;

  always_comb begin
    defl_pop = '0;
    for (int s = 0; s < NSLOT; s++) begin
      defl_pop = defl_pop + SUM_W'(deflected[s]);
    end
    defl_sum = SUM_W'(defl_cnt) + defl_pop;
  end

  // The sum is kept wider than the counter so one request can never wrap it before saturation.
  always_ff @(posedge clk) begin
    if (reset) begin
      defl_cnt <= '0;
    end else if (state == DONE) begin
      if (defl_sum > SUM_W'({CNT_W{1'b1}})) defl_cnt <= '1;
      else defl_cnt <= defl_sum[CNT_W-1:0];
    end
  end
`else
  assign defl_cnt = '0;
`endif

endmodule

// File: tb/tb_deflect_port_alloc.sv
// Directed bench for deflect_port_alloc: expected results are queued at start and checked at done.
// A second instance with CNT_W=2 shares every input and exercises counter saturation.
module tb_deflect_port_alloc;

  localparam int NSLOT = 4;
  localparam int NPORT = 4;
  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  slot_valid;
  logic [15:0] prod_mask;
  logic [3:0]  port_avail;

  logic        busy, done, err;
  logic [15:0] grant;
  logic [3:0]  deflected;
  logic [CNT_W-1:0] defl_cnt;

  logic        busy2, done2, err2;
  logic [15:0] grant2;
  logic [3:0]  deflected2;
  logic [1:0]  defl_cnt2;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  int cnt_model = 0;
  int cnt2_model = 0;

  typedef struct {
    logic [15:0] grant;
    logic [3:0]  defl;
    logic        err;
    int          k;
    int          t0;
  } exp_t;

  exp_t sb[$];

  deflect_port_alloc #(.NSLOT(NSLOT), .NPORT(NPORT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .slot_valid(slot_valid),
    .prod_mask(prod_mask), .port_avail(port_avail), .busy(busy), .done(done),
    .grant(grant), .deflected(deflected), .err(err), .defl_cnt(defl_cnt)
  );

  deflect_port_alloc #(.NSLOT(NSLOT), .NPORT(NPORT), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .slot_valid(slot_valid),
    .prod_mask(prod_mask), .port_avail(port_avail), .busy(busy2), .done(done2),
    .grant(grant2), .deflected(deflected2), .err(err2), .defl_cnt(defl_cnt2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic compare(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic void model(input logic [3:0] v, input logic [15:0] m, input logic [3:0] a,
                                output logic [15:0] g, output logic [3:0] d, output logic e);
    logic [3:0] f;
    logic [3:0] c;
    f = a;
    g = '0;
    d = '0;
    e = 1'b0;
    for (int s = 0; s < 4; s++) begin
      if (v[s]) begin
        c = m[s*4 +: 4] & f;
        if (c == 4'b0000) begin
          if (f == 4'b0000) begin
            e = 1'b1;
            continue;
          end
          c = f;
          d[s] = 1'b1;
        end
        for (int p = 3; p >= 0; p--) begin
          if (c[p]) begin
            g[s*4+p] = 1'b1;
            f[p] = 1'b0;
            break;
          end
        end
      end
    end
  endfunction

  // Called at a negedge; start is seen by the following rising edge.
  task automatic applyStimulus(input logic [3:0] v, input logic [15:0] m, input logic [3:0] a,
                               input logic [15:0] eg, input logic [3:0] ed, input logic ee);
    exp_t e;
    slot_valid = v;
    prod_mask  = m;
    port_avail = a;
    start      = 1'b1;
    e.grant = eg;
    e.defl  = ed;
    e.err   = ee;
    e.k     = $countones(v);
    e.t0    = cycle;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic checkOutput();
    exp_t e;
    int waited;
    int pop;
    waited = 0;
    while (!done && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    e = sb.pop_front();
    compare("done_seen", 32'(done), 32'd1);
    compare("latency", 32'(cycle - e.t0), 32'(1 + e.k));
    compare("busy_at_done", 32'(busy), 32'd1);
    compare("grant", 32'(grant), 32'(e.grant));
    compare("deflected", 32'(deflected), 32'(e.defl));
    compare("err", 32'(err), 32'(e.err));
    compare("grant_sat_inst", 32'(grant2), 32'(e.grant));
    compare("done_sat_inst", 32'(done2), 32'd1);
    pop = $countones(e.defl);
`ifdef DEFLECT_STATS_EN
    cnt_model  = (cnt_model + pop > 65535) ? 65535 : cnt_model + pop;
    cnt2_model = (cnt2_model + pop > 3) ? 3 : cnt2_model + pop;
`else
    cnt_model  = 0;
    cnt2_model = 0;
`endif
    @(negedge clk);
    compare("done_pulse_end", 32'(done), 32'd0);
    compare("busy_after", 32'(busy), 32'd0);
    compare("grant_held", 32'(grant), 32'(e.grant));
    compare("defl_cnt", 32'(defl_cnt), 32'(cnt_model));
    compare("defl_cnt_sat", 32'(defl_cnt2), 32'(cnt2_model));
    compare("err_sat_inst", 32'(err2), 32'(e.err));
    compare("defl_sat_inst", 32'(deflected2), 32'(e.defl));
    compare("busy_sat_inst", 32'(busy2), 32'd0);
  endtask

  initial begin
    logic [3:0]  rv;
    logic [15:0] rm;
    logic [3:0]  ra;
    logic [15:0] eg;
    logic [3:0]  ed;
    logic        ee;
    exp_t        e0;

    reset = 1'b1;
    start = 1'b0;
    slot_valid = '0;
    prod_mask = '0;
    port_avail = '0;
    repeat (2) @(negedge clk);
    compare("reset_busy", 32'(busy), 32'd0);
    compare("reset_done", 32'(done), 32'd0);
    compare("reset_grant", 32'(grant), 32'd0);
    compare("reset_cnt", 32'(defl_cnt), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] contention / saturation");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b0011, 16'h0088, 4'b1011, 16'h0028, 4'b0010, 1'b0);
      checkOutput();
    end

    $display("[TB] all productive");
    applyStimulus(4'b0011, 16'h0048, 4'b1111, 16'h0048, 4'b0000, 1'b0);
    checkOutput();

    $display("[TB] overflow");
    applyStimulus(4'b0111, 16'h0111, 4'b0011, 16'h0021, 4'b0010, 1'b1);
    checkOutput();

    $display("[TB] empty request with ignored restart");
    slot_valid = 4'b0000;
    prod_mask = 16'hFFFF;
    port_avail = 4'b1111;
    start = 1'b1;
    e0.grant = '0;
    e0.defl = '0;
    e0.err = 1'b0;
    e0.k = 0;
    e0.t0 = cycle;
    sb.push_back(e0);
    @(negedge clk);
    slot_valid = 4'b0001;
    checkOutput();
    applyStimulus(4'b0001, 16'h0004, 4'b1111, 16'h0004, 4'b0000, 1'b0);
    checkOutput();

    $display("[TB] pseudo-random requests");
    for (int i = 0; i < 6; i++) begin
      rv = 4'($urandom);
      rm = 16'($urandom);
      ra = 4'($urandom);
      model(rv, rm, ra, eg, ed, ee);
      applyStimulus(rv, rm, ra, eg, ed, ee);
      checkOutput();
    end

    $display("[TB] reset mid-operation");
    slot_valid = 4'b1111;
    prod_mask = 16'h8421;
    port_avail = 4'b1111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cnt_model = 0;
    cnt2_model = 0;
    compare("midrst_busy", 32'(busy), 32'd0);
    compare("midrst_done", 32'(done), 32'd0);
    compare("midrst_grant", 32'(grant), 32'd0);
    compare("midrst_defl", 32'(deflected), 32'd0);
    compare("midrst_err", 32'(err), 32'd0);
    compare("midrst_cnt", 32'(defl_cnt), 32'd0);
    compare("midrst_cnt_sat", 32'(defl_cnt2), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      compare("midrst_no_done", 32'(done), 32'd0);
    end

    applyStimulus(4'b0011, 16'h0088, 4'b1011, 16'h0028, 4'b0010, 1'b0);
    checkOutput();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
